// File: rtl/uart_report_scheduler.sv
// uart_report_scheduler
// Lets several frequency/duty measurement channels share one UART sender.
// Each channel's latest result is buffered. Pending channels are served
// round-robin, one sender transaction at a time, and successive launches
// are spaced by a minimum start-to-start interval.
module uart_report_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int INTERVAL_CYC = 5_000_000,
    parameter int BUSY_TIMEOUT = 1_000_000,
    parameter int CW           = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_CH-1:0]    meas_valid,
    input  logic [8*NUM_CH-1:0]  meas_duty,
    input  logic [34*NUM_CH-1:0] meas_freq,
    input  logic                 clr_overrun,
    input  logic                 tx_busy,
    output logic                 send_en,
    output logic [7:0]           duty,
    output logic [33:0]          freq,
    output logic [CW-1:0]        ch_sel,
    output logic [NUM_CH-1:0]    pending,
    output logic [NUM_CH-1:0]    overrun,
    output logic                 timeout_err
);

    // The counter restarts after the LAUNCH cycle, and IDLE->ARB->LAUNCH
    // takes two more cycles. The threshold is therefore brought forward by
    // three, so the next send_en lands exactly INTERVAL_CYC cycles after the
    // previous one.
    localparam int GAP_LIM = (INTERVAL_CYC > 3) ? INTERVAL_CYC - 3 : 0;
    localparam int GW      = (GAP_LIM > 0) ? $clog2(GAP_LIM + 1) : 1;
    localparam int TW      = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_LIM);
    localparam logic [TW-1:0] TO_MAX  = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [GW-1:0]      gap_cnt_reg, gap_cnt_next;
    logic [TW-1:0]      to_cnt_reg, to_cnt_next;
    logic [NUM_CH-1:0]  pending_reg, pending_next;
    logic [NUM_CH-1:0]  overrun_reg, overrun_next;
    logic               send_en_reg, send_en_next;
    logic               timeout_err_reg, timeout_err_next;
    logic [7:0]         duty_reg, duty_next;
    logic [33:0]        freq_reg, freq_next;
    logic [CW-1:0]      ch_sel_reg, ch_sel_next;

    logic               gap_ok;
    logic               in_wait;
    logic               to_hit;
    logic [CW-1:0]      winner;
    logic               winner_found;
    logic               arb_take;
    logic [NUM_CH-1:0]  arb_clr;

    logic [7:0]         buf_duty [NUM_CH];
    logic [33:0]        buf_freq [NUM_CH];

    // Per-channel result buffers, overwritten by every new measurement.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_buf
            logic [7:0]  duty_buf_reg;
            logic [33:0] freq_buf_reg;

            // Capture this channel's result on its valid pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    duty_buf_reg <= '0;
                    freq_buf_reg <= '0;
                end else if (meas_valid[gi]) begin
                    duty_buf_reg <= meas_duty[8*gi +: 8];
                    freq_buf_reg <= meas_freq[34*gi +: 34];
                end
            end

            assign buf_duty[gi] = duty_buf_reg;
            assign buf_freq[gi] = freq_buf_reg;
        end
    endgenerate

    assign gap_ok   = (gap_cnt_reg >= GAP_MAX);
    assign in_wait  = (state_reg == S_WAIT_BUSY) || (state_reg == S_WAIT_DONE);
    assign to_hit   = in_wait && (to_cnt_reg == TO_MAX);
    assign arb_take = (state_reg == S_ARB) && winner_found;

    // Round-robin search: start after the last served channel and wrap.
    always_comb begin
        logic [CW-1:0] idx;
        winner       = '0;
        winner_found = 1'b0;
        idx          = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = CW'((int'(ch_sel_reg) + k) % NUM_CH);
            if (!winner_found && pending_reg[idx]) begin
                winner_found = 1'b1;
                winner       = idx;
            end
        end
    end

    // Pending/overrun bookkeeping. A new result wins over the ARB clear,
    // and a new overrun wins over clr_overrun.
    always_comb begin
        pending_next = pending_reg;
        overrun_next = overrun_reg;
        arb_clr      = '0;
        if (arb_take) begin
            arb_clr[winner] = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (meas_valid[i] && pending_reg[i] && !arb_clr[i]) begin
                overrun_next[i] = 1'b1;
            end else if (clr_overrun) begin
                overrun_next[i] = 1'b0;
            end
            if (meas_valid[i]) begin
                pending_next[i] = 1'b1;
            end else if (arb_clr[i]) begin
                pending_next[i] = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. Timeout takes priority over the sender handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (enable && (|pending_reg) && gap_ok) begin
                    state_next = S_ARB;
                end
            end
            S_ARB: begin
                state_next = winner_found ? S_LAUNCH : S_IDLE;
            end
            S_LAUNCH: begin
                state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (to_hit) begin
                    state_next = S_IDLE;
                end else if (tx_busy) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (to_hit || !tx_busy) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        send_en_next     = (state_next == S_LAUNCH);
        timeout_err_next = to_hit;
        duty_next        = duty_reg;
        freq_next        = freq_reg;
        ch_sel_next      = ch_sel_reg;
        if (arb_take) begin
            duty_next   = buf_duty[winner];
            freq_next   = buf_freq[winner];
            ch_sel_next = winner;
        end
    end

    // Counter next values. The interval counter saturates. The wait
    // counter runs only while staying in the same wait state, so it clears
    // on LAUNCH->WAIT_BUSY and on WAIT_BUSY->WAIT_DONE.
    always_comb begin
        gap_cnt_next = gap_cnt_reg;
        if (state_reg == S_LAUNCH) begin
            gap_cnt_next = '0;
        end else if (!gap_ok) begin
            gap_cnt_next = gap_cnt_reg + 1'b1;
        end
        if (in_wait && (state_next == state_reg)) begin
            to_cnt_next = to_cnt_reg + 1'b1;
        end else begin
            to_cnt_next = '0;
        end
    end

    // Registered outputs, channel flags and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_en_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
            duty_reg        <= '0;
            freq_reg        <= '0;
            ch_sel_reg      <= '0;
            pending_reg     <= '0;
            overrun_reg     <= '0;
            gap_cnt_reg     <= GAP_MAX;
            to_cnt_reg      <= '0;
        end else begin
            send_en_reg     <= send_en_next;
            timeout_err_reg <= timeout_err_next;
            duty_reg        <= duty_next;
            freq_reg        <= freq_next;
            ch_sel_reg      <= ch_sel_next;
            pending_reg     <= pending_next;
            overrun_reg     <= overrun_next;
            gap_cnt_reg     <= gap_cnt_next;
            to_cnt_reg      <= to_cnt_next;
        end
    end

    assign send_en     = send_en_reg;
    assign timeout_err = timeout_err_reg;
    assign duty        = duty_reg;
    assign freq        = freq_reg;
    assign ch_sel      = ch_sel_reg;
    assign pending     = pending_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_uart_report_scheduler.sv
// Bench for uart_report_scheduler: NUM_CH=4, INTERVAL_CYC=100,
// BUSY_TIMEOUT=50, with a sender model that stays busy for 30 cycles.
module tb_uart_report_scheduler;

    localparam int NUM_CH = 4;
    localparam int INTERVAL = 100;
    localparam int BUSY_LEN = 30;

    logic                 clk;
    logic                 rst_n;
    logic                 enable;
    logic [NUM_CH-1:0]    meas_valid;
    logic [8*NUM_CH-1:0]  meas_duty;
    logic [34*NUM_CH-1:0] meas_freq;
    logic                 clr_overrun;
    logic                 tx_busy;
    logic                 send_en;
    logic [7:0]           duty;
    logic [33:0]          freq;
    logic [1:0]           ch_sel;
    logic [NUM_CH-1:0]    pending;
    logic [NUM_CH-1:0]    overrun;
    logic                 timeout_err;

    uart_report_scheduler #(
        .NUM_CH(NUM_CH),
        .INTERVAL_CYC(INTERVAL),
        .BUSY_TIMEOUT(50)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .meas_valid(meas_valid),
        .meas_duty(meas_duty),
        .meas_freq(meas_freq),
        .clr_overrun(clr_overrun),
        .tx_busy(tx_busy),
        .send_en(send_en),
        .duty(duty),
        .freq(freq),
        .ch_sel(ch_sel),
        .pending(pending),
        .overrun(overrun),
        .timeout_err(timeout_err)
    );

    typedef struct {
        int          ch;
        logic [7:0]  d;
        logic [33:0] f;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   sends_seen = 0;
    int   last_send_cyc = 0;
    int   gap_expect = 0;
    logic mute = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_ch(input int ch, input logic [7:0] d, input logic [33:0] f);
        meas_duty[ch*8 +: 8]  = d;
        meas_freq[ch*34 +: 34] = f;
    endtask

    task automatic push_exp(input int ch, input logic [7:0] d, input logic [33:0] f);
        exp_t e;
        e.ch = ch;
        e.d  = d;
        e.f  = f;
        exp_q.push_back(e);
    endtask

    task automatic fire(input logic [NUM_CH-1:0] mask);
        meas_valid = mask;
        @(posedge clk);
        #1;
        meas_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_sends(input int target, input int bound, input string tag);
        int k = 0;
        while (sends_seen < target && k < bound) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq(tag, 64'(sends_seen), 64'(target));
    endtask

    // Sender model: tx_busy rises one cycle after send_en and lasts BUSY_LEN.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (send_en === 1'b1 && !mute) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (BUSY_LEN) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Scoreboard: every send_en pops the oldest expected report.
    initial begin
        forever begin
            @(negedge clk);
            if (send_en === 1'b1) begin
                exp_t e;
                $display("send %0d: ch=%0d duty=%02h freq=%09h cycle=%0d",
                         sends_seen, ch_sel, duty, freq, cyc);
                check_eq("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("sb_ch", 64'(ch_sel), 64'(e.ch));
                    check_eq("sb_duty", 64'(duty), 64'(e.d));
                    check_eq("sb_freq", 64'(freq), 64'(e.f));
                end
                if (gap_expect > 0) begin
                    check_eq("send_gap", 64'(cyc - last_send_cyc), 64'(gap_expect));
                end
                last_send_cyc = cyc;
                sends_seen++;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n0;
        rst_n       = 1'b0;
        enable      = 1'b1;
        meas_valid  = '0;
        meas_duty   = '0;
        meas_freq   = '0;
        clr_overrun = 1'b0;
        idle(3);

        // Reset values
        check_eq("rst_send_en", 64'(send_en), 64'd0);
        check_eq("rst_timeout_err", 64'(timeout_err), 64'd0);
        check_eq("rst_duty", 64'(duty), 64'd0);
        check_eq("rst_freq", 64'(freq), 64'd0);
        check_eq("rst_ch_sel", 64'(ch_sel), 64'd0);
        check_eq("rst_pending", 64'(pending), 64'd0);
        check_eq("rst_overrun", 64'(overrun), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Single channel, latency of two cycles to send_en
        set_ch(2, 8'h32, 34'h12345);
        push_exp(2, 8'h32, 34'h12345);
        fire(4'b0100);
        check_eq("t1_pending_set", 64'(pending), 64'b0100);
        idle(1);
        check_eq("t1_arb_no_send", 64'(send_en), 64'd0);
        idle(1);
        check_eq("t1_send_en", 64'(send_en), 64'd1);
        check_eq("t1_duty", 64'(duty), 64'h32);
        check_eq("t1_freq", 64'(freq), 64'h12345);
        check_eq("t1_ch_sel", 64'(ch_sel), 64'd2);
        check_eq("t1_pending_clr", 64'(pending), 64'd0);
        idle(150);

        // Bring ch_sel to 0, then round-robin 1, 3, 0 at exact spacing
        set_ch(0, 8'h10, 34'h100);
        push_exp(0, 8'h10, 34'h100);
        fire(4'b0001);
        wait_sends(2, 20, "t2_pre_send");
        idle(150);
        set_ch(0, 8'hA0, 34'h2_0000_0001);
        set_ch(1, 8'hA1, 34'h1_2345_6789);
        set_ch(3, 8'hA3, 34'h3_FFFF_FFFF);
        push_exp(1, 8'hA1, 34'h1_2345_6789);
        push_exp(3, 8'hA3, 34'h3_FFFF_FFFF);
        push_exp(0, 8'hA0, 34'h2_0000_0001);
        gap_expect = 0;
        fire(4'b1011);
        wait_sends(3, 20, "t2_first_send");
        gap_expect = INTERVAL;
        wait_sends(5, 300, "t2_all_sends");
        gap_expect = 0;
        idle(150);

        // Overrun: second value overwrites and is reported
        enable = 1'b0;
        set_ch(1, 8'h11, 34'h111);
        fire(4'b0010);
        set_ch(1, 8'h22, 34'h222);
        fire(4'b0010);
        check_eq("t3_overrun_set", 64'(overrun), 64'b0010);
        check_eq("t3_pending", 64'(pending), 64'b0010);
        push_exp(1, 8'h22, 34'h222);
        enable = 1'b1;
        wait_sends(6, 20, "t3_send");
        idle(150);
        enable = 1'b0;
        clr_overrun = 1'b1;
        idle(1);
        clr_overrun = 1'b0;
        check_eq("t3_overrun_clr", 64'(overrun), 64'd0);
        set_ch(1, 8'h44, 34'h444);
        fire(4'b0010);
        check_eq("t3_no_overrun", 64'(overrun), 64'd0);
        set_ch(1, 8'h55, 34'h555);
        clr_overrun = 1'b1;
        fire(4'b0010);
        clr_overrun = 1'b0;
        check_eq("t3_set_wins_clr", 64'(overrun), 64'b0010);
        clr_overrun = 1'b1;
        idle(1);
        clr_overrun = 1'b0;
        check_eq("t3_overrun_clr2", 64'(overrun), 64'd0);
        push_exp(1, 8'h55, 34'h555);
        enable = 1'b1;
        wait_sends(7, 20, "t3_send2");
        idle(150);

        // New result on the winner during its ARB cycle
        enable = 1'b0;
        set_ch(2, 8'h61, 34'h6161);
        fire(4'b0100);
        push_exp(2, 8'h61, 34'h6161);
        push_exp(2, 8'h62, 34'h6262);
        enable = 1'b1;
        idle(1);
        set_ch(2, 8'h62, 34'h6262);
        meas_valid = 4'b0100;
        idle(1);
        meas_valid = '0;
        check_eq("t4_send_en", 64'(send_en), 64'd1);
        check_eq("t4_old_duty", 64'(duty), 64'h61);
        check_eq("t4_pending_kept", 64'(pending), 64'b0100);
        check_eq("t4_no_overrun", 64'(overrun), 64'd0);
        wait_sends(8, 5, "t4_first");
        gap_expect = INTERVAL;
        wait_sends(9, 200, "t4_second");
        gap_expect = 0;
        idle(150);

        // Sender never busy: timeout, then the next pending channel
        mute = 1'b1;
        set_ch(3, 8'h73, 34'h7373);
        set_ch(0, 8'h70, 34'h7070);
        push_exp(3, 8'h73, 34'h7373);
        push_exp(0, 8'h70, 34'h7070);
        fire(4'b1001);
        wait_sends(10, 20, "t5_first");
        gap_expect = INTERVAL;
        k = 0;
        while (timeout_err !== 1'b1 && k < 200) begin
            idle(1);
            k++;
        end
        check_eq("t5_timeout_delay", 64'(cyc - last_send_cyc), 64'd51);
        idle(1);
        check_eq("t5_timeout_pulse", 64'(timeout_err), 64'd0);
        mute = 1'b0;
        wait_sends(11, 200, "t5_next_ch");
        gap_expect = 0;
        n0 = sends_seen;
        idle(150);
        check_eq("t5_no_resend", 64'(sends_seen), 64'(n0));

        // Reset during WAIT_DONE, then hold off until enable
        set_ch(1, 8'h81, 34'h8181);
        push_exp(1, 8'h81, 34'h8181);
        fire(4'b0010);
        wait_sends(12, 20, "t6_send");
        idle(3);
        set_ch(3, 8'h83, 34'h8383);
        fire(4'b1000);
        fire(4'b1000);
        check_eq("t6_pre_pending", 64'(pending), 64'b1000);
        check_eq("t6_pre_overrun", 64'(overrun), 64'b1000);
        check_eq("t6_pre_duty", 64'(duty), 64'h81);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_send_en", 64'(send_en), 64'd0);
        check_eq("t6_rst_duty", 64'(duty), 64'd0);
        check_eq("t6_rst_freq", 64'(freq), 64'd0);
        check_eq("t6_rst_ch_sel", 64'(ch_sel), 64'd0);
        check_eq("t6_rst_pending", 64'(pending), 64'd0);
        check_eq("t6_rst_overrun", 64'(overrun), 64'd0);
        enable = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        set_ch(2, 8'h92, 34'h9292);
        push_exp(2, 8'h92, 34'h9292);
        fire(4'b0100);
        n0 = sends_seen;
        idle(150);
        check_eq("t6_held_no_send", 64'(sends_seen), 64'(n0));
        check_eq("t6_held_pending", 64'(pending), 64'b0100);
        enable = 1'b1;
        idle(2);
        check_eq("t6_send_after_en", 64'(send_en), 64'd1);
        check_eq("t6_ch_sel", 64'(ch_sel), 64'd2);
        idle(150);
        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
